// File: rtl/imem_arbiter.sv
// Single-port SRAM arbiter: boot writes take priority during boot, instr/data share round-robin.
// Grant is combinational in the request cycle; the response (rvalid/rdata/err) follows one cycle later.
module imem_arbiter #(
    parameter int MEM_AW = 10,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              boot_active,
    input  logic              boot_req,
    input  logic [31:0]       boot_addr,
    input  logic [DW-1:0]     boot_wdata,
    output logic              boot_gnt,
    input  logic              instr_req,
    input  logic [31:0]       instr_addr,
    output logic              instr_gnt,
    output logic              instr_rvalid,
    output logic [DW-1:0]     instr_rdata,
    output logic              instr_err,
    input  logic              data_req,
    input  logic              data_we,
    input  logic [DW/8-1:0]   data_be,
    input  logic [31:0]       data_addr,
    input  logic [DW-1:0]     data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DW-1:0]     data_rdata,
    output logic              data_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DW/8-1:0]   mem_be,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [DW-1:0]     mem_wdata,
    input  logic [DW-1:0]     mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_INSTR = 2'd1,
        OWN_DATA  = 2'd2
    } owner_t;

    typedef enum logic {
        LAST_INSTR = 1'b0,
        LAST_DATA  = 1'b1
    } last_t;

    owner_t      r_resp_owner;
    logic        r_resp_err;
    logic        r_resp_we;
    last_t       r_last;

    logic        w_boot_gnt;
    logic        w_instr_gnt;
    logic        w_data_gnt;
    logic        w_core_gnt;
    logic        w_in_range;
    logic        w_mem_req;
    logic [31:0] w_sel_addr;
    logic [DW-1:0] w_resp_rdata;
    logic        w_unused_addr_lsb;

    // With both ports requesting, the port that was not served last wins.
    assign w_boot_gnt  = boot_active & boot_req;
    assign w_instr_gnt = ~boot_active & instr_req & (~data_req  | (r_last == LAST_DATA));
    assign w_data_gnt  = ~boot_active & data_req  & (~instr_req | (r_last == LAST_INSTR));
    assign w_core_gnt  = w_instr_gnt | w_data_gnt;

    assign boot_gnt  = w_boot_gnt;
    assign instr_gnt = w_instr_gnt;
    assign data_gnt  = w_data_gnt;

    always_comb begin
        w_sel_addr = '0;
        if (w_boot_gnt) begin
            w_sel_addr = boot_addr;
        end else if (w_instr_gnt) begin
            w_sel_addr = instr_addr;
        end else if (w_data_gnt) begin
            w_sel_addr = data_addr;
        end
    end

    assign w_in_range        = ((w_sel_addr >> (MEM_AW + 2)) == 32'd0);
    assign w_mem_req         = (w_boot_gnt | w_core_gnt) & w_in_range;
    assign w_unused_addr_lsb = ^w_sel_addr[1:0];

    assign mem_req = w_mem_req;

    always_comb begin
        mem_we    = 1'b0;
        mem_be    = '0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (w_mem_req) begin
            mem_addr = w_sel_addr[MEM_AW+1:2];
            if (w_boot_gnt) begin
                mem_we    = 1'b1;
                mem_be    = '1;
                mem_wdata = boot_wdata;
            end else if (w_data_gnt) begin
                mem_we    = data_we;
                mem_be    = data_be;
                mem_wdata = data_wdata;
            end else begin
                mem_be    = '1;
            end
        end
    end

    // Boot writes get no response slot; out-of-range boot writes vanish here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_owner <= OWN_NONE;
            r_resp_err   <= 1'b0;
            r_resp_we    <= 1'b0;
            r_last       <= LAST_INSTR;
        end else begin
            r_resp_err <= w_core_gnt & ~w_in_range;
            r_resp_we  <= w_data_gnt & data_we;
            if (w_instr_gnt) begin
                r_resp_owner <= OWN_INSTR;
                r_last       <= LAST_INSTR;
            end else if (w_data_gnt) begin
                r_resp_owner <= OWN_DATA;
                r_last       <= LAST_DATA;
            end else begin
                r_resp_owner <= OWN_NONE;
            end
        end
    end

    assign w_resp_rdata = (r_resp_err | r_resp_we) ? '0 : mem_rdata;

    assign instr_rvalid = (r_resp_owner == OWN_INSTR);
    assign instr_err    = instr_rvalid & r_resp_err;
    assign instr_rdata  = instr_rvalid ? w_resp_rdata : '0;

    assign data_rvalid  = (r_resp_owner == OWN_DATA);
    assign data_err     = data_rvalid & r_resp_err;
    assign data_rdata   = data_rvalid ? w_resp_rdata : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter with an SRAM model and a transaction-level reference model.
module tb_imem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        boot_active, boot_req, boot_gnt;
    logic [31:0] boot_addr, boot_wdata;
    logic        instr_req, instr_gnt, instr_rvalid, instr_err;
    logic [31:0] instr_addr, instr_rdata;
    logic        data_req, data_we, data_gnt, data_rvalid, data_err;
    logic [3:0]  data_be;
    logic [31:0] data_addr, data_wdata, data_rdata;
    logic        mem_req, mem_we;
    logic [3:0]  mem_be;
    logic [9:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int errors = 0;
    int checks = 0;

    logic [31:0] sram    [1024];
    logic [31:0] ref_mem [1024];

    always #5 clk = ~clk;

    imem_arbiter #(.MEM_AW(10), .DW(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .boot_active(boot_active), .boot_req(boot_req), .boot_addr(boot_addr),
        .boot_wdata(boot_wdata), .boot_gnt(boot_gnt),
        .instr_req(instr_req), .instr_addr(instr_addr), .instr_gnt(instr_gnt),
        .instr_rvalid(instr_rvalid), .instr_rdata(instr_rdata), .instr_err(instr_err),
        .data_req(data_req), .data_we(data_we), .data_be(data_be), .data_addr(data_addr),
        .data_wdata(data_wdata), .data_gnt(data_gnt), .data_rvalid(data_rvalid),
        .data_rdata(data_rdata), .data_err(data_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Synchronous SRAM with byte-enable writes and 1-cycle read latency.
    always @(posedge clk) begin
        if (mem_req) begin
            if (mem_we) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be[b]) sram[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
            end else begin
                mem_rdata <= sram[mem_addr];
            end
        end
    end

    // Reference model: who should win, what the SRAM should see, what comes back next cycle.
    int          m_pend;        // 0 none, 1 instr, 2 data
    logic [31:0] m_pend_rdata;
    logic        m_pend_err;
    bit          m_last_data;
    logic        e_b, e_i, e_d, e_inr;
    logic [31:0] e_a;
    logic [9:0]  e_w;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_instr_rvalid", instr_rvalid, 0);
            chk("rst_data_rvalid", data_rvalid, 0);
            chk("rst_instr_err", instr_err, 0);
            chk("rst_data_err", data_err, 0);
            chk("rst_instr_rdata", instr_rdata, 0);
            chk("rst_data_rdata", data_rdata, 0);
            m_pend      = 0;
            m_last_data = 0;
        end else begin
            chk("instr_rvalid", instr_rvalid, m_pend == 1);
            chk("data_rvalid", data_rvalid, m_pend == 2);
            chk("instr_err", instr_err, (m_pend == 1) && m_pend_err);
            chk("data_err", data_err, (m_pend == 2) && m_pend_err);
            chk("instr_rdata", instr_rdata, (m_pend == 1) ? m_pend_rdata : 32'h0);
            chk("data_rdata", data_rdata, (m_pend == 2) ? m_pend_rdata : 32'h0);

            e_b = boot_active && boot_req;
            e_i = !boot_active && instr_req && (!data_req || m_last_data);
            e_d = !boot_active && data_req && (!instr_req || !m_last_data);
            chk("boot_gnt", boot_gnt, e_b);
            chk("instr_gnt", instr_gnt, e_i);
            chk("data_gnt", data_gnt, e_d);

            e_a   = e_b ? boot_addr : e_i ? instr_addr : e_d ? data_addr : 32'h0;
            e_inr = (e_a < 32'h0000_1000);
            e_w   = e_a[11:2];
            chk("mem_req", mem_req, (e_b || e_i || e_d) && e_inr);
            if ((e_b || e_i || e_d) && e_inr) begin
                chk("mem_addr", mem_addr, e_w);
                chk("mem_we", mem_we, e_b || (e_d && data_we));
                if (e_b) begin
                    chk("mem_be_boot", mem_be, 4'hF);
                    chk("mem_wdata_boot", mem_wdata, boot_wdata);
                    ref_mem[e_w] = boot_wdata;
                end
                if (e_d) begin
                    chk("mem_be_data", mem_be, data_be);
                    if (data_we) begin
                        chk("mem_wdata_data", mem_wdata, data_wdata);
                        for (int b = 0; b < 4; b++)
                            if (data_be[b]) ref_mem[e_w][8*b +: 8] = data_wdata[8*b +: 8];
                    end
                end
            end

            if (e_i || e_d) begin
                m_pend       = e_i ? 1 : 2;
                m_pend_err   = !e_inr;
                m_pend_rdata = (!e_inr || (e_d && data_we)) ? 32'h0 : ref_mem[e_w];
            end else begin
                m_pend = 0;
            end
            if (e_i) m_last_data = 0;
            if (e_d) m_last_data = 1;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        boot_active = 0; boot_req = 0; instr_req = 0; data_req = 0; data_we = 0;
    endtask

    string seq;

    initial begin
        for (int i = 0; i < 1024; i++) begin
            sram[i]    = 32'hA500_0000 | i;
            ref_mem[i] = 32'hA500_0000 | i;
        end
        sram[4] = 32'h0000_0013; ref_mem[4] = 32'h0000_0013;
        mem_rdata = 0;
        rst_n = 0;
        boot_addr = 0; boot_wdata = 0; instr_addr = 0;
        data_addr = 0; data_wdata = 0; data_be = 4'hF;
        idle();
        repeat (3) step();

        // 1: release with no requests
        rst_n = 1;
        step();
        #2;
        chk("t1_gnt", {boot_gnt, instr_gnt, data_gnt}, 0);
        chk("t1_mem_req", mem_req, 0);
        chk("t1_rvalid", {instr_rvalid, data_rvalid, instr_err, data_err}, 0);

        // 2: single fetch
        step();
        instr_req = 1; instr_addr = 32'h10;
        #2;
        chk("t2_gnt", instr_gnt, 1);
        chk("t2_mem_addr", mem_addr, 4);
        step();
        idle();
        #2;
        chk("t2_rvalid", instr_rvalid, 1);
        chk("t2_rdata", instr_rdata, 32'h13);

        // 3: both requesting after a fresh reset alternate starting with data
        rst_n = 0; step(); step(); rst_n = 1; step();
        instr_req = 1; data_req = 1; instr_addr = 32'h40; data_addr = 32'h80;
        seq = "";
        for (int i = 0; i < 6; i++) begin
            #2;
            seq = {seq, data_gnt ? "D" : instr_gnt ? "I" : "-"};
            step();
        end
        idle();
        checks++;
        if (seq != "DIDIDI") begin
            errors++;
            $display("FAIL t3_order: got %s expected DIDIDI", seq);
        end

        // 4: partial write then read back
        step();
        data_req = 1; data_we = 1; data_be = 4'b0011; data_addr = 32'h20; data_wdata = 32'hDEADBEEF;
        #2;
        chk("t4_mem_we", mem_we, 1);
        chk("t4_mem_be", mem_be, 4'b0011);
        step();
        data_we = 0; data_be = 4'hF;
        #2;
        chk("t4_wr_rvalid", data_rvalid, 1);
        chk("t4_wr_rdata", data_rdata, 0);
        step();
        idle();
        #2;
        chk("t4_rd_rdata", data_rdata, 32'hA500_BEEF);

        // 5: out-of-range read
        step();
        data_req = 1; data_addr = 32'h0001_0000;
        #2;
        chk("t5_gnt", data_gnt, 1);
        chk("t5_mem_req", mem_req, 0);
        step();
        idle();
        #2;
        chk("t5_rvalid", data_rvalid, 1);
        chk("t5_err", data_err, 1);
        chk("t5_rdata", data_rdata, 0);

        // 6: boot window opens with a fetch in flight
        step();
        instr_req = 1; instr_addr = 32'h10;
        step();
        boot_active = 1; boot_req = 1; boot_addr = 32'h0; boot_wdata = 32'h1122_3344;
        instr_req = 1; data_req = 1; instr_addr = 32'h0; data_addr = 32'h80;
        #2;
        chk("t6_inflight_rvalid", instr_rvalid, 1);
        chk("t6_inflight_rdata", instr_rdata, 32'h13);
        chk("t6_core_gnt", {instr_gnt, data_gnt}, 0);
        chk("t6_boot_gnt", boot_gnt, 1);
        step();
        boot_addr = 32'h4;
        #2;
        chk("t6_boot_addr1", mem_addr, 1);
        step();
        boot_addr = 32'h0001_0000;
        #2;
        chk("t6_boot_oor_req", mem_req, 0);
        step();
        boot_active = 0; boot_req = 0;
        #2;
        chk("t6_resume_data", data_gnt, 1);
        step();
        data_req = 0;
        #2;
        chk("t6_fetch_gnt", instr_gnt, 1);
        step();
        idle();
        #2;
        chk("t6_fetch_booted", instr_rdata, 32'h1122_3344);

        // 7: request withdrawn without a grant
        step();
        boot_active = 1; instr_req = 1;
        step();
        idle();
        #2;
        chk("t7_no_rvalid", instr_rvalid, 0);

        // 8: reset during an access drops its response
        step();
        data_req = 1; data_addr = 32'h20;
        #2;
        rst_n = 0;
        step();
        idle();
        step();
        rst_n = 1;
        step();
        #2;
        chk("t8_no_rvalid", data_rvalid, 0);

        step();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
Name: imem_arbiter

Overview:
- Single-port arbiter for the shared instruction/data SRAM behind the ibex core.
- Three requesters share one synchronous memory port (1-cycle read latency):
  - instruction fetch port;
  - data port, which reaches the arbiter after bus_mux address decode;
  - BootLoader write port.
- Boot writes have absolute priority while the boot reset is asserted. Instruction and data ports are served round-robin.
- Out-of-range addresses are answered with an error response and no memory access.

Parameters:
- MEM_AW, 10, word-address width of the SRAM (depth = 2^MEM_AW words).
- DW, 32, data width; byte enables are DW/8 bits wide.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- boot_active  in  1  BootLoader reset/load window (RstBoot).
- boot_req  in  1  boot write request.
- boot_addr  in  32  boot byte address.
- boot_wdata  in  DW  boot write data.
- boot_gnt  out  1  boot grant.
- instr_req  in  1  fetch request.
- instr_addr  in  32  fetch byte address.
- instr_gnt  out  1  fetch grant.
- instr_rvalid  out  1  fetch response valid.
- instr_rdata  out  DW  fetch data.
- instr_err  out  1  fetch error.
- data_req  in  1  data request.
- data_we  in  1  data write enable.
- data_be  in  DW/8  data byte enables.
- data_addr  in  32  data byte address.
- data_wdata  in  DW  data write data.
- data_gnt  out  1  data grant.
- data_rvalid  out  1  data response valid.
- data_rdata  out  DW  data read data.
- data_err  out  1  data error.
- mem_req  out  1  SRAM access strobe.
- mem_we  out  1  SRAM write.
- mem_be  out  DW/8  SRAM byte enables.
- mem_addr  out  MEM_AW  SRAM word address.
- mem_wdata  out  DW  SRAM write data.
- mem_rdata  in  DW  SRAM read data, valid the cycle after mem_req.

Behaviour:

Reset values:
- rst_n low clears all registers asynchronously.
- resp_owner = NONE, resp_err = 0, last = INSTR.
- All rvalid/err outputs are 0 and all rdata outputs are 0.

Grant logic:
- Combinational, same cycle as the request; at most one grant per cycle.

Priority:
- boot_active = 1:
  - boot_gnt = boot_req; instr_gnt = data_gnt = 0.
  - Boot access is always a write: be = all ones, we = 1.
- boot_active = 0:
  - boot_gnt = 0.
  - If only one of instr/data requests, that one is granted.
  - If both request, the one not equal to `last` is granted.
  - `last` updates to the granted port on every instr/data grant.

Address check:
- In range means addr[31:MEM_AW+2] == 0.
- The access uses word address addr[MEM_AW+1:2]; addr[1:0] is ignored.
- Out-of-range accesses are still granted, but mem_req = 0 and the error flag is latched.

SRAM port:
- mem_req = (any grant) & in_range.
- mem_we/be/addr/wdata are driven from the granted port.
- When idle, mem_* outputs are 0.
- Out-of-range boot writes are dropped silently: no error, no access.

Response pipeline (1 stage):
- resp_owner <= granted port (INSTR, DATA or NONE); boot gets no response.
- resp_err <= !in_range.
- Next cycle, the owner sees rvalid = 1, err = resp_err, rdata = mem_rdata (0 on error or for writes).
- The non-owner port's rvalid/rdata/err stay 0.

Throughput and ordering:
- A new grant is allowed every cycle: back-to-back and interleaved instr/data accesses run at full rate.
- Responses stay in order, one per grant.

Writes:
- Data writes produce rvalid one cycle after the grant, with rdata = 0.

Boundary cases:
- boot_active rising with a response in flight: the in-flight response is still delivered the next cycle.
- While boot_active = 1, no new instr/data grants are issued.
- boot_active falling: arbitration resumes the same cycle. `last` is unchanged by boot traffic.
- A requester deasserting req without a grant is legal and has no side effects.
- Asynchronous reset mid-access: the response is dropped; no rvalid follows reset release.

Test Plan:
1. Reset hold, then release with no requests -> all gnt/rvalid/err = 0, mem_req = 0.
2. instr_req at 0x0000_0010, SRAM word 4 = 0x0000_0013 -> instr_gnt same cycle; mem_addr = 4; next cycle instr_rvalid = 1, instr_rdata = 0x0000_0013.
3. instr and data requesting continuously for 6 cycles, last = INSTR after reset -> grants alternate D, I, D, I, D, I; each rvalid is routed to the matching port one cycle later.
4. data write 0xDEADBEEF, be = 4'b0011 at 0x0000_0020, then data read of the same address -> mem_we = 1, mem_be = 0011; write rvalid has rdata = 0; read returns 0x????BEEF (low half updated).
5. data read at 0x0001_0000 with MEM_AW = 10 -> data_gnt = 1, mem_req = 0; next cycle data_rvalid = 1, data_err = 1, data_rdata = 0.
6. boot_active asserted while instr and data are requesting and a read is in flight -> the pending rvalid is still delivered; instr/data grants stay 0 and boot writes of 0x11223344 land at each boot_addr; after boot_active drops, instr fetch from 0 returns the booted word.
